load_store_unit: RTL and testbench

Load/store initiator between the datapath's execute stage and the word-addressed, synchronous-read `DataMemory`. Accepts one RISC-V load or store request at a time and drives `memRead`/`memWrite`, a word address and write data. Byte/halfword loads are handled by extraction and sign/zero extension; sub-word stores by read-modify-write. Returns the aligned load result with a one-cycle `done` pulse and flags misaligned or out-of-range accesses.

---
 rtl/load_store_unit_if.sv | 28 ++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave is the unit's view; master is the execute stage plus memory.
interface load_store_unit_if;
  logic        start;
  logic        ready;
  logic        isStore;
  logic [2:0]  funct3;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [31:0] loadData;
  logic        done;
  logic        error;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] memReadData;

  modport slave (
    input  start, isStore, funct3, address, storeData, memReadData,
    output ready, loadData, done, error, memAddress, memWriteData, memWrite, memRead
  );

  modport master (
    output start, isStore, funct3, address, storeData, memReadData,
    input  ready, loadData, done, error, memAddress, memWriteData, memWrite, memRead
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store initiator for a word-addressed, synchronous-read data memory.
// Define LSU_SUBWORD_EN for b/h/bu/hu loads and read-modify-write sb/sh; otherwise only lw/sw.
module load_store_unit #(
  parameter int MEM_WORDS = 32
) (
  input logic             clock,
  input logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [2:0] F3_W = 3'b010;
`ifdef LSU_SUBWORD_EN
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
`endif

  state_t      state, state_nx;
  logic        err_q;
  logic [31:0] load_data_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_write_data_q;
`ifdef LSU_SUBWORD_EN
  logic        is_store_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] store_data_q;
`endif

  logic        accept;
  logic        funct3_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        req_bad;
  logic [31:0] req_word;

  assign accept       = bus.start && (state == S_IDLE);
  assign req_word     = {2'b00, bus.address[31:2]};
  assign out_of_range = req_word >= 32'(MEM_WORDS);
  assign req_bad      = !funct3_ok || misaligned || out_of_range;

  // Access width is encoded in funct3[1:0]; byte accesses can never be misaligned.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    misaligned = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misaligned = bus.address[0];
      2'b10:   misaligned = bus.address[1:0] != 2'b00;
      default: misaligned = 1'b0;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  always_comb begin
    funct3_ok = 1'b0;
    case (bus.funct3)
      F3_B, F3_H, F3_W: funct3_ok = 1'b1;
      F3_BU, F3_HU:     funct3_ok = !bus.isStore;
      default:          funct3_ok = 1'b0;
    endcase
  end
`else
  assign funct3_ok = bus.funct3 == F3_W;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (req_bad)                               state_nx = S_DONE;
          else if (bus.isStore && bus.funct3 == F3_W) state_nx = S_WRITE;
          else                                       state_nx = S_READ;
        end
      end
      S_READ:  state_nx = S_MERGE;
`ifdef LSU_SUBWORD_EN
      S_MERGE: state_nx = is_store_q ? S_WRITE : S_DONE;
`else
      S_MERGE: state_nx = S_DONE;
`endif
      S_WRITE: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef LSU_SUBWORD_EN
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] merged_word;

  // Lane extraction/extension for loads and lane replacement for sb/sh share the lane select.
  always_comb begin
    rd_byte     = 8'h00;
    rd_half     = lane_q[1] ? bus.memReadData[31:16] : bus.memReadData[15:0];
    load_ext    = bus.memReadData;
    merged_word = bus.memReadData;
    case (lane_q)
      2'd0:    rd_byte = bus.memReadData[7:0];
      2'd1:    rd_byte = bus.memReadData[15:8];
      2'd2:    rd_byte = bus.memReadData[23:16];
      default: rd_byte = bus.memReadData[31:24];
    endcase
    case (funct3_q)
      F3_B:    load_ext = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_ext = {24'h0, rd_byte};
      F3_H:    load_ext = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_ext = {16'h0, rd_half};
      default: load_ext = bus.memReadData;
    endcase
    if (funct3_q == F3_B) begin
      case (lane_q)
        2'd0:    merged_word[7:0]   = store_data_q[7:0];
        2'd1:    merged_word[15:8]  = store_data_q[7:0];
        2'd2:    merged_word[23:16] = store_data_q[7:0];
        default: merged_word[31:24] = store_data_q[7:0];
      endcase
    end else if (funct3_q == F3_H) begin
      if (lane_q[1]) merged_word[31:16] = store_data_q[15:0];
      else           merged_word[15:0]  = store_data_q[15:0];
    end
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      err_q            <= 1'b0;
      load_data_q      <= '0;
      mem_address_q    <= '0;
      mem_write_data_q <= '0;
`ifdef LSU_SUBWORD_EN
      is_store_q       <= 1'b0;
      funct3_q         <= '0;
      lane_q           <= '0;
      store_data_q     <= '0;
`endif
    end else begin
      state <= state_nx;
      if (accept) begin
        err_q            <= req_bad;
        load_data_q      <= '0;
        mem_address_q    <= req_word;
        mem_write_data_q <= bus.storeData;
`ifdef LSU_SUBWORD_EN
        is_store_q       <= bus.isStore;
        funct3_q         <= bus.funct3;
        lane_q           <= bus.address[1:0];
        store_data_q     <= bus.storeData;
`endif
      end
      if (state == S_MERGE) begin
`ifdef LSU_SUBWORD_EN
        if (is_store_q) mem_write_data_q <= merged_word;
        else            load_data_q      <= load_ext;
`else
        load_data_q <= bus.memReadData;
`endif
      end
    end
  end

  // Strobes decode from state alone so an asynchronous reset drops them at once.
  assign bus.ready        = state == S_IDLE;
  assign bus.done         = state == S_DONE;
  assign bus.error        = (state == S_DONE) && err_q;
  assign bus.memRead      = state == S_READ;
  assign bus.memWrite     = state == S_WRITE;
  assign bus.loadData     = load_data_q;
  assign bus.memAddress   = mem_address_q;
  assign bus.memWriteData = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized requests
// against a byte-lane arithmetic model and a behavioural synchronous-read memory.
module tb_load_store_unit;
  localparam int MEM_WORDS = 32;
`ifdef LSU_SUBWORD_EN
  localparam bit SUBWORD = 1'b1;
`else
  localparam bit SUBWORD = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  load_store_unit_if bus ();
  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (.clock(clock), .reset(reset), .bus(bus));

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] rdata;
  logic        bd_we;
  logic [4:0]  bd_idx;
  logic [31:0] bd_data;

  assign bus.memReadData = rdata;

  // NOTE: the memory array is never reset; its contents must survive an LSU reset.
  always @(posedge clock) begin
    if (bd_we) mem[bd_idx] <= bd_data;
    if (bus.memWrite && bus.memAddress < 32'(MEM_WORDS)) mem[bus.memAddress[4:0]] <= bus.memWriteData;
    if (bus.memRead && bus.memAddress < 32'(MEM_WORDS)) rdata <= mem[bus.memAddress[4:0]];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Expected outcome of one request, from the RISC-V access rules on byte lanes.
  function automatic void model(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] sd, input logic [31:0] word,
                                output bit err, output int lat, output logic [31:0] ld,
                                output logic [31:0] nw);
    bit legal;
    int nbytes, sh;
    logic [31:0] mask, lane;
    if (!SUBWORD)  legal = (f3 == 3'd2);
    else if (st)   legal = (f3 <= 3'd2);
    else           legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    nbytes = 1 << f3[1:0];
    err = !legal || ((addr % nbytes) != 0) || ((addr >> 2) >= MEM_WORDS);
    ld = '0;
    nw = word;
    if (err) begin
      lat = 1;
      return;
    end
    sh   = 8 * int'(addr[1:0]);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    lane = (word >> sh) & mask;
    if (nbytes == 4)      ld = word;
    else if (!f3[2] && lane[8 * nbytes - 1]) ld = lane | ~mask;
    else                  ld = lane;
    if (st) nw = (word & ~(mask << sh)) | ((sd & mask) << sh);
    lat = !st ? 3 : (nbytes == 4) ? 2 : 4;
  endfunction

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clock);
    bd_we = 1'b1; bd_idx = 5'(idx); bd_data = data;
    @(posedge clock);
    #1 bd_we = 1'b0;
    ref_mem[idx] = data;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 10 && !bus.ready; i++) @(negedge clock);
    check({tag, " ready"}, 32'(bus.ready), 32'd1);
  endtask

  task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] sd, input string tag);
    bit err, both;
    int lat, idx, rd_n, wr_n, rd_c, wr_c, done_c;
    logic [31:0] ld, nw, wr_data, strobe_addr, got_ld, word;
    logic got_err;
    idx  = ((addr >> 2) < MEM_WORDS) ? int'(addr[6:2]) : -1;
    word = (idx >= 0) ? ref_mem[idx] : 32'h0;
    model(st, f3, addr, sd, word, err, lat, ld, nw);
    @(negedge clock);
    wait_ready(tag);
    bus.start = 1'b1; bus.isStore = st; bus.funct3 = f3; bus.address = addr; bus.storeData = sd;
    @(posedge clock);
    rd_n = 0; wr_n = 0; rd_c = 0; wr_c = 0; done_c = 0; both = 1'b0;
    wr_data = '0; strobe_addr = '0; got_ld = '0; got_err = 1'b0;
    for (int c = 1; c <= 8 && done_c == 0; c++) begin
      @(negedge clock);
      if (bus.memRead)  begin rd_n++; rd_c = c; strobe_addr = bus.memAddress; end
      if (bus.memWrite) begin wr_n++; wr_c = c; wr_data = bus.memWriteData; strobe_addr = bus.memAddress; end
      if (bus.memRead && bus.memWrite) both = 1'b1;
      if (bus.done) begin done_c = c; got_err = bus.error; got_ld = bus.loadData; end
      if (c == 1) begin
        bus.start = 1'b0; bus.isStore = ~st; bus.funct3 = 3'($urandom);
        bus.address = $urandom; bus.storeData = $urandom;
      end
    end
    check({tag, " done cycle"}, 32'(done_c), 32'(lat));
    check({tag, " error"}, 32'(got_err), 32'(err));
    if (!err && !st) check({tag, " loadData"}, got_ld, ld);
    check({tag, " reads"}, 32'(rd_n), (!err && (!st || f3 != 3'd2)) ? 32'd1 : 32'd0);
    check({tag, " writes"}, 32'(wr_n), (!err && st) ? 32'd1 : 32'd0);
    check({tag, " rd+wr overlap"}, 32'(both), 32'd0);
    if (!err && rd_n == 1) check({tag, " read cycle"}, 32'(rd_c), 32'd1);
    if (!err && st) begin
      check({tag, " write cycle"}, 32'(wr_c), 32'(lat - 1));
      check({tag, " memWriteData"}, wr_data, nw);
    end
    if (!err) check({tag, " memAddress"}, strobe_addr, addr >> 2);
    @(negedge clock);
    check({tag, " ready after done"}, 32'(bus.ready), 32'd1);
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    if (idx >= 0) begin
      if (st && !err) ref_mem[idx] = nw;
      check({tag, " mem word"}, mem[idx], ref_mem[idx]);
    end
  endtask

  initial begin
    bit err;
    int lat, dones, exp_dones;
    logic [31:0] ld, nw, sd, addr;

    reset = 1'b1; bd_we = 1'b0; bd_idx = '0; bd_data = '0;
    bus.start = 1'b0; bus.isStore = 1'b0; bus.funct3 = '0; bus.address = '0; bus.storeData = '0;
    #12;
    check("rst ready", 32'(bus.ready), 32'd1);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst error", 32'(bus.error), 32'd0);
    check("rst memRead", 32'(bus.memRead), 32'd0);
    check("rst memWrite", 32'(bus.memWrite), 32'd0);
    check("rst loadData", bus.loadData, 32'd0);
    check("rst memAddress", bus.memAddress, 32'd0);
    check("rst memWriteData", bus.memWriteData, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < MEM_WORDS; i++) poke(i, $urandom);

    poke(3, 32'h8000_00F0);
    do_op(1'b0, 3'd2, 32'h0C, 32'h0, "lw 0x0C");
    do_op(1'b0, 3'd0, 32'h0C, 32'h0, "lb 0x0C");
    do_op(1'b0, 3'd4, 32'h0C, 32'h0, "lbu 0x0C");
    do_op(1'b0, 3'd1, 32'h0E, 32'h0, "lh 0x0E");
    do_op(1'b0, 3'd5, 32'h0E, 32'h0, "lhu 0x0E");

    poke(3, 32'h1122_3344);
    do_op(1'b1, 3'd0, 32'h0D, 32'h0000_00AB, "sb 0x0D");
    do_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, "sw 0x10");
    do_op(1'b0, 3'd2, 32'h0E, 32'h0, "lw misaligned");
    do_op(1'b1, 3'd1, 32'h0F, 32'h1234, "sh misaligned");
    do_op(1'b0, 3'd2, 32'h80, 32'h0, "lw out of range");
    do_op(1'b0, 3'd3, 32'h08, 32'h0, "illegal load f3");
    do_op(1'b1, 3'd4, 32'h08, 32'h0, "illegal store f3");

    // start held high through a busy sb: one accept per (latency+1) cycles.
    sd = 32'h0000_00CD;
    model(1'b1, 3'd0, 32'h0D, sd, ref_mem[3], err, lat, ld, nw);
    @(negedge clock);
    wait_ready("held");
    bus.start = 1'b1; bus.isStore = 1'b1; bus.funct3 = 3'd0; bus.address = 32'h0D; bus.storeData = sd;
    @(posedge clock);
    dones = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (bus.done) dones++;
      if (i == 10) bus.start = 1'b0;
    end
    exp_dones = 0;
    for (int a = 0; a * (lat + 1) + lat <= 10; a++) exp_dones++;
    check("held start done count", 32'(dones), 32'(exp_dones));
    repeat (6) @(negedge clock);
    if (!err) ref_mem[3] = nw;
    check("held start mem word", mem[3], ref_mem[3]);

    // reset pulsed during WRITE: strobe drops at once and the word is untouched.
    @(negedge clock);
    wait_ready("reset mid-write");
    addr = 32'h14;
    bus.start = 1'b1; bus.isStore = 1'b1; bus.funct3 = 3'd2; bus.address = addr; bus.storeData = ~ref_mem[5];
    @(posedge clock);
    @(negedge clock);
    bus.start = 1'b0;
    check("write cycle memWrite", 32'(bus.memWrite), 32'd1);
    reset = 1'b1;
    #1;
    check("reset memWrite", 32'(bus.memWrite), 32'd0);
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset done", 32'(bus.done), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset target word", mem[5], ref_mem[5]);

    for (int n = 0; n < 200; n++) begin
      int widx;
      widx = $urandom_range(0, MEM_WORDS + 7);
      addr = (32'(widx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) addr = $urandom;
      do_op(1'($urandom), 3'($urandom), addr, $urandom, $sformatf("rand%0d", n));
    end

    for (int i = 0; i < MEM_WORDS; i++) check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
